// File: rtl/mips_pkg.sv
// Shared definitions for the branch/PC control slice: FSM encoding, PC step,
// counter width and the saturating-increment helper.
package mips_pkg;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_SQUASH = 1'b1
  } br_state_e;

  localparam logic [31:0] PC_INC = 32'd4;
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val, input logic en);
    logic [CNT_W-1:0] res;
    if (en && (val != CNT_MAX)) begin
      res = val + CNT_ONE;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_target_adder.sv
// Combinational branch target: pc4 + (sign-extended imm << 2), wrapping mod 2^32.
module branch_target_adder (
  input  logic [31:0] pc4,
  input  logic [15:0] imm,
  output logic [31:0] target
);

  logic [31:0] offset_s;

  // Word-aligned signed offset and the wrapping add.
  always_comb begin
    offset_s = {{14{imm[15]}}, imm, 2'b00};
    target   = pc4 + offset_s;
  end

endmodule

// File: rtl/pc_branch_ctrl.sv
// Fetch PC sequencing with taken-branch redirect, pipeline squash FSM and
// saturating branch statistics.
module pc_branch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FLUSH_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   br_valid,
  input  logic                   br_taken,
  input  logic [31:0]            br_pc4,
  input  logic [15:0]            br_imm,
  output logic [31:0]            pc,
  output logic [FLUSH_DEPTH-1:0] flush,
  output logic                   redirect,
  output logic [CNT_W-1:0]       br_count,
  output logic [CNT_W-1:0]       taken_count
);

  localparam logic [1:0] SQ_LOAD = 2'(FLUSH_DEPTH - 1);

  br_state_e   state_r;
  br_state_e   state_s;
  logic [1:0]  sq_cnt_r;
  logic [1:0]  sq_cnt_s;
  logic [31:0] pc_s;
  logic [31:0] target_s;
  logic        accept_s;
  logic        take_s;

  branch_target_adder u_target (
    .pc4    (br_pc4),
    .imm    (br_imm),
    .target (target_s)
  );

  // Next-state, squash countdown and next-PC selection; branches are only seen in RUN.
  always_comb begin
    state_s  = state_r;
    sq_cnt_s = sq_cnt_r;
    accept_s = 1'b0;
    take_s   = 1'b0;
    pc_s     = pc;
    case (state_r)
      ST_RUN: begin
        accept_s = br_valid;
        take_s   = br_valid & br_taken;
        if (take_s) begin
          state_s  = ST_SQUASH;
          sq_cnt_s = SQ_LOAD;
        end else begin
          state_s  = ST_RUN;
          sq_cnt_s = sq_cnt_r;
        end
      end
      ST_SQUASH: begin
        if (sq_cnt_r == 2'd0) begin
          state_s  = ST_RUN;
          sq_cnt_s = 2'd0;
        end else begin
          state_s  = ST_SQUASH;
          sq_cnt_s = sq_cnt_r - 2'd1;
        end
      end
      default: begin
        state_s  = ST_RUN;
        sq_cnt_s = 2'd0;
      end
    endcase
    // A taken branch overrides stall; stall otherwise freezes the PC only.
    if (take_s) begin
      pc_s = target_s;
    end else if (!stall) begin
      pc_s = pc + PC_INC;
    end else begin
      pc_s = pc;
    end
  end

  // Flush is a direct decode of the squash state.
  always_comb begin
    if (state_r == ST_SQUASH) begin
      flush = {FLUSH_DEPTH{1'b1}};
    end else begin
      flush = {FLUSH_DEPTH{1'b0}};
    end
  end

  // State, PC, redirect pulse and statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      sq_cnt_r    <= 2'd0;
      pc          <= RESET_PC;
      redirect    <= 1'b0;
      br_count    <= {CNT_W{1'b0}};
      taken_count <= {CNT_W{1'b0}};
    end else begin
      state_r     <= state_s;
      sq_cnt_r    <= sq_cnt_s;
      pc          <= pc_s;
      redirect    <= take_s;
      br_count    <= sat_inc(br_count, accept_s);
      taken_count <= sat_inc(taken_count, take_s);
    end
  end

endmodule

// File: tb/tb_pc_branch_ctrl.sv
// Directed, table-driven bench for pc_branch_ctrl with hand-written reset and saturation sequences.
module tb_pc_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic [31:0] br_pc4;
  logic [15:0] br_imm;
  logic [31:0] pc;
  logic [1:0]  flush;
  logic        redirect;
  logic [15:0] br_count;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        bt;
    logic [31:0] pc4;
    logic [15:0] imm;
    logic [31:0] e_pc;
    logic [1:0]  e_flush;
    logic        e_redir;
    logic [15:0] e_bc;
    logic [15:0] e_tc;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  pc_branch_ctrl #(.RESET_PC(32'h0000_0000), .FLUSH_DEPTH(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_taken    (br_taken),
    .br_pc4      (br_pc4),
    .br_imm      (br_imm),
    .pc          (pc),
    .flush       (flush),
    .redirect    (redirect),
    .br_count    (br_count),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic bv, input logic bt,
                              input logic [31:0] pc4, input logic [15:0] imm,
                              input logic [31:0] epc, input logic [1:0] efl,
                              input logic erd, input logic [15:0] ebc, input logic [15:0] etc);
    vec_t v;
    v.stall = s; v.bv = bv; v.bt = bt; v.pc4 = pc4; v.imm = imm;
    v.e_pc = epc; v.e_flush = efl; v.e_redir = erd; v.e_bc = ebc; v.e_tc = etc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic bv, input logic bt,
                       input logic [31:0] pc4, input logic [15:0] imm);
    stall = s; br_valid = bv; br_taken = bt; br_pc4 = pc4; br_imm = imm;
  endtask

  initial begin
    vecs[0]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h4,         2'b00, 1'b0, 16'd0, 16'd0);
    vecs[1]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h8,         2'b00, 1'b0, 16'd0, 16'd0);
    vecs[2]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'hC,         2'b00, 1'b0, 16'd0, 16'd0);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 32'h100,       16'h0004, 32'h110,       2'b11, 1'b1, 16'd1, 16'd1);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h114,       2'b11, 1'b0, 16'd1, 16'd1);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h118,       2'b00, 1'b0, 16'd1, 16'd1);
    vecs[6]  = mk(1'b0, 1'b1, 1'b1, 32'h100,       16'hFFFE, 32'hF8,        2'b11, 1'b1, 16'd2, 16'd2);
    vecs[7]  = mk(1'b0, 1'b1, 1'b1, 32'h200,       16'h0010, 32'hFC,        2'b11, 1'b0, 16'd2, 16'd2);
    vecs[8]  = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h100,       2'b00, 1'b0, 16'd2, 16'd2);
    vecs[9]  = mk(1'b0, 1'b1, 1'b0, 32'h100,       16'hFFFE, 32'h104,       2'b00, 1'b0, 16'd3, 16'd2);
    vecs[10] = mk(1'b1, 1'b0, 1'b0, 32'h0,         16'h0,    32'h104,       2'b00, 1'b0, 16'd3, 16'd2);
    vecs[11] = mk(1'b1, 1'b1, 1'b1, 32'h400,       16'h0100, 32'h800,       2'b11, 1'b1, 16'd4, 16'd3);
    vecs[12] = mk(1'b1, 1'b0, 1'b0, 32'h0,         16'h0,    32'h800,       2'b11, 1'b0, 16'd4, 16'd3);
    vecs[13] = mk(1'b1, 1'b0, 1'b0, 32'h0,         16'h0,    32'h800,       2'b00, 1'b0, 16'd4, 16'd3);
    vecs[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h804,       2'b00, 1'b0, 16'd4, 16'd3);
    vecs[15] = mk(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 16'h0001, 32'hFFFF_FFFC, 2'b11, 1'b1, 16'd5, 16'd4);
    vecs[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h0,         2'b11, 1'b0, 16'd5, 16'd4);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h4,         2'b00, 1'b0, 16'd5, 16'd4);
    vecs[18] = mk(1'b0, 1'b1, 1'b1, 32'h1000_0000, 16'h7FFF, 32'h1001_FFFC, 2'b11, 1'b1, 16'd6, 16'd5);
    vecs[19] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h1002_0000, 2'b11, 1'b0, 16'd6, 16'd5);
    vecs[20] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h1002_0004, 2'b00, 1'b0, 16'd6, 16'd5);
    vecs[21] = mk(1'b0, 1'b1, 1'b1, 32'h0002_0000, 16'h8000, 32'h0,         2'b11, 1'b1, 16'd7, 16'd6);
    vecs[22] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h4,         2'b11, 1'b0, 16'd7, 16'd6);
    vecs[23] = mk(1'b0, 1'b0, 1'b0, 32'h0,         16'h0,    32'h8,         2'b00, 1'b0, 16'd7, 16'd6);
    vecs[24] = mk(1'b0, 1'b0, 1'b1, 32'h300,       16'h0004, 32'hC,         2'b00, 1'b0, 16'd7, 16'd6);

    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    repeat (2) @(negedge clk);
    chk("reset pc", pc, 32'h0);
    chk("reset flush", {30'd0, flush}, 32'h0);
    chk("reset redirect", {31'd0, redirect}, 32'h0);
    chk("reset br_count", {16'd0, br_count}, 32'h0);
    chk("reset taken_count", {16'd0, taken_count}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].stall, vecs[i].bv, vecs[i].bt, vecs[i].pc4, vecs[i].imm);
      @(negedge clk);
      chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
      chk($sformatf("v%0d flush", i), {30'd0, flush}, {30'd0, vecs[i].e_flush});
      chk($sformatf("v%0d redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_redir});
      chk($sformatf("v%0d br_count", i), {16'd0, br_count}, {16'd0, vecs[i].e_bc});
      chk($sformatf("v%0d taken_count", i), {16'd0, taken_count}, {16'd0, vecs[i].e_tc});
    end

    // Reset asserted mid-cycle while a squash is in progress.
    drive(1'b0, 1'b1, 1'b1, 32'h100, 16'h0004);
    @(negedge clk);
    chk("pre-reset flush", {30'd0, flush}, 32'h3);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset pc", pc, 32'h0);
    chk("midreset flush", {30'd0, flush}, 32'h0);
    chk("midreset redirect", {31'd0, redirect}, 32'h0);
    chk("midreset br_count", {16'd0, br_count}, 32'h0);
    chk("midreset taken_count", {16'd0, taken_count}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset pc", pc, 32'h4);
    chk("post-reset flush", {30'd0, flush}, 32'h0);
    @(negedge clk);
    chk("post-reset pc2", pc, 32'h8);

    // br_count saturation via back-to-back not-taken branches.
    drive(1'b0, 1'b1, 1'b0, 32'h100, 16'h0004);
    repeat (65534) @(negedge clk);
    chk("br_count FFFE", {16'd0, br_count}, 32'h0000_FFFE);
    @(negedge clk);
    chk("br_count FFFF", {16'd0, br_count}, 32'h0000_FFFF);
    repeat (3) @(negedge clk);
    chk("br_count sat", {16'd0, br_count}, 32'h0000_FFFF);
    chk("taken_count untouched", {16'd0, taken_count}, 32'h0);
    chk("no flush not-taken", {30'd0, flush}, 32'h0);

    // taken_count saturation: preload near the top, then keep branching.
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    force dut.taken_count = 16'hFFFE;
    #1 release dut.taken_count;
    drive(1'b0, 1'b1, 1'b1, 32'h100, 16'h0004);
    @(negedge clk);
    chk("taken_count FFFF", {16'd0, taken_count}, 32'h0000_FFFF);
    chk("sat redirect1", {31'd0, redirect}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h200, 16'h0004);
    @(negedge clk);
    chk("taken_count sat", {16'd0, taken_count}, 32'h0000_FFFF);
    chk("sat redirect2", {31'd0, redirect}, 32'h1);
    chk("sat pc", pc, 32'h210);
    chk("sat br_count", {16'd0, br_count}, 32'h0000_FFFF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
